// File: rtl/register_file_param.sv
// Parametrised register bank: one byte-masked write port, two independent read ports,
// per-word sticky valid scoreboard, optional hardwired zero word, combinational or registered reads.
module register_file_param #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned ZERO_REG = 0,
   parameter int unsigned REG_READ = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic [WIDTH/8-1:0]      wmask,
   input  logic [ADDR_W-1:0]       raddr_a,
   output logic [WIDTH-1:0]        rdata_a,
   output logic                    rvalid_a,
   input  logic [ADDR_W-1:0]       raddr_b,
   output logic [WIDTH-1:0]        rdata_b,
   output logic                    rvalid_b,
   output logic [(2**ADDR_W)-1:0]  valid_map
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned LANES = WIDTH / 8;
   localparam logic [DEPTH-1:0] VALID_INIT = {{(DEPTH-1){1'b0}}, (ZERO_REG != 0)};

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]  valid;
   logic [WIDTH-1:0]  lane_bits;
   logic [WIDTH-1:0]  merged;
   logic              wr_commit;
   logic [ADDR_W-1:0] raddr [2];
   logic [WIDTH-1:0]  look_data [2];
   logic              look_valid [2];

   always_comb begin
      lane_bits = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_bits[8*i +: 8] = {8{wmask[i]}};
      end
   end

   assign merged    = (mem[waddr] & ~lane_bits) | (wdata & lane_bits);
   assign wr_commit = we && !rst && !clr && (wmask != '0) && !((ZERO_REG != 0) && (waddr == '0));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         valid <= VALID_INIT;
      end else if (wr_commit) begin
         mem[waddr]   <= merged;
         valid[waddr] <= 1'b1;
      end
   end

   assign valid_map = valid;
   assign raddr[0]  = raddr_a;
   assign raddr[1]  = raddr_b;

   // Look-ahead view: the word as it will stand after this edge's write; serves both
   // as the combinational bypass and as the write-first source of the read registers.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         look_data[p]  = mem[raddr[p]];
         look_valid[p] = valid[raddr[p]];
         if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
            look_data[p]  = '0;
            look_valid[p] = 1'b1;
         end else if (we && !rst && !clr && (raddr[p] == waddr)) begin
            look_data[p]  = merged;
            look_valid[p] = valid[waddr] | (wmask != '0);
         end
      end
   end

   if (REG_READ != 0) begin : g_reg_read
      logic [WIDTH-1:0] q_data [2];
      logic             q_valid [2];

      always_ff @(posedge clk) begin
         for (int unsigned p = 0; p < 2; p++) begin
            if (rst) begin
               q_data[p]  <= '0;
               q_valid[p] <= 1'b0;
            end else if (clr) begin
               q_data[p]  <= '0;
               q_valid[p] <= (ZERO_REG != 0) && (raddr[p] == '0);
            end else begin
               q_data[p]  <= look_data[p];
               q_valid[p] <= look_valid[p];
            end
         end
      end

      assign rdata_a  = q_data[0];
      assign rvalid_a = q_valid[0];
      assign rdata_b  = q_data[1];
      assign rvalid_b = q_valid[1];
   end else begin : g_comb_read
      assign rdata_a  = look_data[0];
      assign rvalid_a = look_valid[0];
      assign rdata_b  = look_data[1];
      assign rvalid_b = look_valid[1];
   end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: four configurations (ZERO_REG x REG_READ) share one
// stimulus stream and are checked every cycle against a word/valid array model.
module tb_register_file_param;

   logic        clk;
   logic        rst, clr, we;
   logic [2:0]  waddr, raddr_a, raddr_b;
   logic [15:0] wdata;
   logic [1:0]  wmask;

   logic [3:0][15:0] rd_a, rd_b;
   logic [3:0]       rv_a, rv_b;
   logic [3:0][7:0]  vmap;

   int tests = 0;
   int fails = 0;

   // config c: ZERO_REG = c%2, REG_READ = c/2
   for (genvar g = 0; g < 4; g++) begin : g_dut
      register_file_param #(
         .WIDTH(16), .ADDR_W(3), .ZERO_REG(g % 2), .REG_READ(g / 2)
      ) dut (
         .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
         .wmask(wmask), .raddr_a(raddr_a), .rdata_a(rd_a[g]), .rvalid_a(rv_a[g]),
         .raddr_b(raddr_b), .rdata_b(rd_b[g]), .rvalid_b(rv_b[g]), .valid_map(vmap[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_mem [4][8];
   logic [7:0]  m_val [4];
   logic [15:0] e_rd  [4][2];
   logic        e_rv  [4][2];
   bit          ready = 0;

   function automatic void stored_view(input int c, input logic [2:0] a,
                                       output logic [15:0] d, output logic v);
      if (c % 2 == 1 && a == 3'd0) begin
         d = 16'h0000;
         v = 1'b1;
      end else begin
         d = m_mem[c][a];
         v = m_val[c][a];
      end
   endfunction

   function automatic void live_view(input int c, input logic [2:0] a,
                                     output logic [15:0] d, output logic v);
      stored_view(c, a, d, v);
      if (we && !rst && !clr && a == waddr && !(c % 2 == 1 && a == 3'd0)) begin
         for (int b = 0; b < 2; b++)
            if (wmask[b]) d[8*b +: 8] = wdata[8*b +: 8];
         if (wmask != 2'b00) v = 1'b1;
      end
   endfunction

   // Inputs seen at a falling edge are exactly those sampled at the next rising edge.
   task automatic advance_model();
      logic [15:0] d;
      logic        v;
      logic [2:0]  a;
      for (int c = 0; c < 4; c++) begin
         if (rst || clr) begin
            for (int w = 0; w < 8; w++) m_mem[c][w] = 16'h0000;
            m_val[c] = (c % 2 == 1) ? 8'h01 : 8'h00;
         end else if (we && wmask != 2'b00 && !(c % 2 == 1 && waddr == 3'd0)) begin
            for (int b = 0; b < 2; b++)
               if (wmask[b]) m_mem[c][waddr][8*b +: 8] = wdata[8*b +: 8];
            m_val[c][waddr] = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? raddr_a : raddr_b;
            if (rst) begin
               d = 16'h0000;
               v = 1'b0;
            end else begin
               stored_view(c, a, d, v);
            end
            e_rd[c][p] = d;
            e_rv[c][p] = v;
         end
      end
      if (rst) ready = 1;
   endtask

   initial begin
      logic [15:0] d;
      logic        v;
      forever begin
         @(negedge clk);
         if (ready) begin
            for (int c = 0; c < 4; c++) begin
               for (int p = 0; p < 2; p++) begin
                  if (c / 2 == 1) begin
                     d = e_rd[c][p];
                     v = e_rv[c][p];
                  end else begin
                     live_view(c, (p == 0) ? raddr_a : raddr_b, d, v);
                  end
                  chk($sformatf("cfg%0d rdata_%s", c, p == 0 ? "a" : "b"),
                      p == 0 ? rd_a[c] : rd_b[c], d);
                  chk($sformatf("cfg%0d rvalid_%s", c, p == 0 ? "a" : "b"),
                      {15'd0, p == 0 ? rv_a[c] : rv_b[c]}, {15'd0, v});
               end
               chk($sformatf("cfg%0d valid_map", c), {8'd0, vmap[c]}, {8'd0, m_val[c]});
            end
         end
         advance_model();
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; clr = 0; we = 0; waddr = 0; wdata = 0; wmask = 0; raddr_a = 0; raddr_b = 0;
      step(); step();

      rst = 0; raddr_a = 3; raddr_b = 5; #2;
      chk("reset rdata_a", rd_a[0], 16'h0000);
      chk("reset rvalid_a", {15'd0, rv_a[0]}, 16'd0);
      chk("reset rdata_b", rd_b[0], 16'h0000);
      chk("reset reg rvalid_b", {15'd0, rv_b[2]}, 16'd0);
      chk("reset valid_map", {8'd0, vmap[0]}, 16'h0000);
      chk("reset valid_map zero", {8'd0, vmap[1]}, 16'h0001);
      step();

      we = 1; waddr = 2; wdata = 16'hA5C3; wmask = 2'b11; raddr_a = 2; #2;
      chk("bypass full write", rd_a[0], 16'hA5C3);
      step();
      wdata = 16'h1234; wmask = 2'b01; #2;
      chk("bypass masked merge", rd_a[0], 16'hA534);
      step();
      we = 0; #2;
      chk("masked stored", rd_a[0], 16'hA534);
      chk("masked registered", rd_a[2], 16'hA534);
      chk("valid_map word2", {8'd0, vmap[0]}, 16'h0004);
      step();

      we = 1; waddr = 6; raddr_a = 6; wdata = 16'hBEEF; wmask = 2'b11; #2;
      chk("bypass same cycle", rd_a[0], 16'hBEEF);
      chk("bypass rvalid", {15'd0, rv_a[0]}, 16'd1);
      chk("registered no bypass", rd_a[2], 16'hA534);
      step();
      we = 0; #2;
      chk("registered after edge", rd_a[2], 16'hBEEF);
      chk("registered rvalid", {15'd0, rv_a[2]}, 16'd1);
      step();

      we = 1; waddr = 0; wdata = 16'hFFFF; wmask = 2'b11; raddr_a = 0; step();
      waddr = 1; wdata = 16'h1111; wmask = 2'b00; raddr_b = 1; #2;
      chk("mask0 bypass rvalid", {15'd0, rv_b[0]}, 16'd0);
      step();
      we = 0; #2;
      chk("zero reg rdata", rd_a[1], 16'h0000);
      chk("zero reg rvalid", {15'd0, rv_a[1]}, 16'd1);
      chk("zero reg valid_map", {8'd0, vmap[1]}, 16'h0045);
      chk("zero reg registered", rd_a[3], 16'h0000);
      chk("zero reg reg rvalid", {15'd0, rv_a[3]}, 16'd1);
      chk("word0 normal", rd_a[0], 16'hFFFF);
      chk("word0 normal map", {8'd0, vmap[0]}, 16'h0045);
      chk("mask0 no valid", {15'd0, rv_b[1]}, 16'd0);
      step();

      we = 1; waddr = 1; wdata = 16'h0101; wmask = 2'b11; step();
      waddr = 4; wdata = 16'h0404; step();
      we = 0; #2;
      chk("map before clr", {8'd0, vmap[0]}, 16'h0057);
      step();
      clr = 1; we = 1; waddr = 7; wdata = 16'h5555; wmask = 2'b11; raddr_a = 7; raddr_b = 0; #2;
      chk("clr blocks bypass", rd_a[0], 16'h0000);
      chk("clr blocks bypass v", {15'd0, rv_a[0]}, 16'd0);
      step();
      clr = 0; we = 0; #2;
      chk("clr map", {8'd0, vmap[0]}, 16'h0000);
      chk("clr map zero", {8'd0, vmap[1]}, 16'h0001);
      chk("clr word7", rd_a[0], 16'h0000);
      chk("clr reg word7", rd_a[2], 16'h0000);
      chk("clr reg zero rvalid", {15'd0, rv_b[3]}, 16'd1);
      chk("clr word0", rd_b[0], 16'h0000);
      step();

      we = 1; waddr = 1; wdata = 16'h0101; wmask = 2'b11; step();
      waddr = 4; wdata = 16'h0404; step();
      rst = 1; waddr = 7; wdata = 16'h5555; step();
      rst = 0; we = 0; #2;
      chk("rst map", {8'd0, vmap[0]}, 16'h0000);
      chk("rst map zero", {8'd0, vmap[1]}, 16'h0001);
      chk("rst word7", rd_a[0], 16'h0000);
      chk("rst reg word7", rd_a[2], 16'h0000);
      chk("rst reg zero rvalid", {15'd0, rv_b[3]}, 16'd0);
      step();

      for (int i = 0; i < 1000; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         clr   = ($urandom_range(0, 49) == 0);
         we    = ($urandom_range(0, 3) != 0);
         waddr = 3'($urandom_range(0, 7));
         wdata = 16'($urandom);
         wmask = 2'($urandom_range(0, 3));
         raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
         raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
         step();
      end
      rst = 0; clr = 0; we = 0;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
